// File: rtl/demux_rr_scheduler.sv
// Round-robin time-slot scheduler sharing one 1-to-16 demux.
// Grants one requester for up to DWELL cycles, then idles GAP cycles.
module demux_rr_scheduler #(
    parameter int DWELL = 8,
    parameter int GAP   = 1,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] req,
    input  logic [15:0] din,
    output logic [15:0] gnt,
    output logic [3:0]  sel,
    output logic        dm_d,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_GAP
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_CNT = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GAP_CNT   = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       ptr_q, ptr_d;
    logic [3:0]       sel_q, sel_d;

    logic       win_vld;
    logic [3:0] win_idx;
    logic [3:0] cand;
    logic       slot_end;
    logic       arb;

    // Search from ptr+1 around to ptr itself; last-served goes last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr_q;
        cand    = ptr_q;
        for (int i = 1; i <= 16; i++) begin
            cand = ptr_q + 4'(i);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign slot_end = (state_q == S_GRANT) &&
                      ((cnt_q == '0) || !req[sel_q]);

    // Next-state: slot timing, gap timing and re-arbitration.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        arb     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                arb = 1'b1;
            end
            S_GRANT: begin
                if (slot_end) begin
                    if (GAP > 0) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_CNT;
                    end else begin
                        arb = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    arb = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (arb) begin
            if (en && win_vld) begin
                state_d = S_GRANT;
                sel_d   = win_idx;
                ptr_d   = win_idx;
                cnt_d   = DWELL_CNT;
            end else begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        end
    end

    // State register; reset aborts any slot silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= 4'hF;
            sel_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
        end
    end

    // Outputs decoded from registered state; data passes only in GRANT.
    always_comb begin
        gnt = '0;
        if (state_q == S_GRANT) begin
            gnt[sel_q] = 1'b1;
        end
        dm_d = (state_q == S_GRANT) && din[sel_q];
        busy = (state_q != S_IDLE);
        done = slot_end;
        sel  = sel_q;
    end

endmodule
